// File: rtl/tx_gearbox.sv
// tx_gearbox: 66b->32b transmit gearbox for 10GBASE-R. It packs header+2x32b blocks into a 32b stream.
// A 33-cycle sequence accepts 32 words and emits 33, so upstream stalls once per sequence.
module tx_gearbox #(
    localparam int DATA_WIDTH     = 32,
    localparam int HEADER_WIDTH   = 2,
    localparam int SEQUENCE_WIDTH = 6
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic [HEADER_WIDTH-1:0] i_header,
    output logic                    o_ready,
    output logic                    o_header_ready,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_data_valid
);
    localparam int APP_WIDTH  = DATA_WIDTH + HEADER_WIDTH;
    localparam int COMB_WIDTH = 2 * DATA_WIDTH + HEADER_WIDTH;

    logic [SEQUENCE_WIDTH-1:0] seq_q, seq_d, lvl_q, lvl_d;
    logic [DATA_WIDTH-1:0]     pend_q, pend_d, data_d;
    logic                      ready_d, hdr_d;
    logic [APP_WIDTH-1:0]      app;
    logic [6:0]                app_w;
    logic [COMB_WIDTH-1:0]     pend_x, app_x, comb;

    // o_ready/o_header_ready describe the word consumed at the coming edge
    assign app    = !o_ready ? '0 : o_header_ready ? {i_data, i_header} : {{HEADER_WIDTH{1'b0}}, i_data};
    assign app_w  = !o_ready ? 7'd0 : o_header_ready ? 7'd34 : 7'd32;
    assign pend_x = {{(COMB_WIDTH - DATA_WIDTH){1'b0}}, pend_q};
    assign app_x  = {{(COMB_WIDTH - APP_WIDTH){1'b0}}, app};

    always_comb begin
        comb = '0;
        for (int i = 0; i < COMB_WIDTH; i++) begin
            comb[i] = (7'(i) < {1'b0, lvl_q}) ? pend_x[i] : app_x[7'(i) - {1'b0, lvl_q}];
        end
        seq_d   = !o_data_valid ? '0 : (seq_q == 6'd32) ? '0 : seq_q + 6'd1;
        lvl_d   = o_data_valid ? 6'(7'(lvl_q) + app_w - 7'd32) : '0;
        pend_d  = comb[2*DATA_WIDTH-1:DATA_WIDTH];
        data_d  = comb[DATA_WIDTH-1:0];
        ready_d = seq_d != 6'd32;
        hdr_d   = (seq_d != 6'd32) && !seq_d[0];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            seq_q          <= '0;
            lvl_q          <= '0;
            pend_q         <= '0;
            o_data         <= '0;
            o_data_valid   <= 1'b0;
            o_ready        <= 1'b0;
            o_header_ready <= 1'b0;
        end else begin
            seq_q          <= seq_d;
            lvl_q          <= lvl_d;
            pend_q         <= pend_d;
            o_data         <= data_d;
            o_data_valid   <= 1'b1;
            o_ready        <= ready_d;
            o_header_ready <= hdr_d;
        end
    end

    // buffer must be empty at every sequence start and the 2 margin bits never reached
    assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (lvl_q <= 6'd32) && (seq_q != 6'd0 || lvl_q == 6'd0) && (comb[COMB_WIDTH-1:2*DATA_WIDTH] == 2'b00));
endmodule

// File: doc/tx_gearbox.md
# tx_gearbox

Transmit-side 66b→32b gearbox for the 10GBASE-R PCS. It takes scrambled 64b/66b blocks from the encoder/scrambler as a 2-bit sync header plus two 32-bit data words. It packs them into a continuous stream of 32-bit words for the transceiver TX data port. A free-running 33-cycle sequence counter paces input acceptance: 32 words are accepted and 33 words are emitted per sequence, so upstream is stalled exactly one cycle in 33.

## Interface
Parameters (fixed as localparams):
- DATA_WIDTH, 32, width of the input data word and the output word.
- HEADER_WIDTH, 2, width of the sync header.
- SEQUENCE_WIDTH, 6, width of the sequence counter (range 0..32).

Ports:
- i_clk  input  1  single clock, rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_data  input  32  scrambled block data word. Bit 0 is transmitted first.
- i_header  input  2  sync header. Sampled only when o_header_ready=1. Bit 0 is transmitted first.
- o_ready  output  1  registered. Upstream must present a new i_data word on every cycle where this is 1.
- o_header_ready  output  1  registered. High when the word being accepted is the first word of a 66b block.
- o_data  output  32  registered gearboxed word to the transceiver. Bit 0 is transmitted first.
- o_data_valid  output  1  registered. Low in reset; high from the first edge after reset release.

## Operation
- Sequence counter seq runs 0..32, increments every cycle and wraps 32→0. There is no slip input; TX alignment is fixed.
- Per-cycle input class, by seq:
  - seq even, 0..30: header word. Appended bits are {i_data, i_header} (34 bits, header in the LSBs). o_header_ready=1, o_ready=1.
  - seq odd, 1..31: second word of the block. Appended bits are i_data (32 bits). o_header_ready=0, o_ready=1.
  - seq 32: no input. 0 bits appended. o_ready=0, o_header_ready=0. i_data and i_header are ignored.
- Pending buffer: up to 32 residual bits, held LSB-aligned, with a level counter L in the range 0..32.
- Each cycle, form combined = {appended bits, pending[L-1:0]}. Pending bits are always sent before new bits.
  - o_data <= combined[31:0].
  - pending <= combined >> 32.
  - L <= L + appended_width − 32.
- L trajectory: 0 after reset.
  - After seq 2j (j=0..15): L = 2(j+1).
  - Odd seq leaves L unchanged.
  - After seq 31: L = 32.
  - seq 32 drains the buffer to L = 0.
  - L must read 0 at every seq=0. An assertion checks this, and also checks that L never exceeds 32.
- Maximum combined width is 64 bits, reached at seq 30 (L=30 + 34). Size the datapath to 66 bits to give margin.
- Implement bit placement as per-bit selects (no variable-width part-selects), for iverilog compatibility.

## Timing
- Reset (i_reset_n=0, asynchronous assert), every output and internal register takes this value:
  - seq=0, L=0, pending=0.
  - o_data=0, o_data_valid=0, o_ready=0, o_header_ready=0.
- Reset deassertion is synchronous to i_clk and must be externally synchronised.
- o_ready and o_header_ready are registered from next-seq. At the first edge after release they become 1 and 1, because seq 0 is a header word.
- Handshake: on an edge where o_ready=1, i_data (and i_header if o_header_ready=1) is consumed unconditionally. There is no valid input; upstream must always have data.
- Latency: bits sampled at edge n appear, where they fit, in o_data after edge n. Bits that do not fit are carried in pending and appear at edge n+1.
- o_data_valid goes to 1 at the first edge after release and stays 1 until reset.
- Reset mid-sequence: the buffer is discarded immediately, with no flush. The sequence restarts at seq 0 with a header word.

## Test plan
- Reset values: hold i_reset_n=0 → all outputs 0. Release → after edge 1, o_ready=1, o_header_ready=1, o_data_valid=1.
- First block: header 2'b10, data A=32'hFFFF_FFFF, B=32'h0000_0000 → o_data=32'hFFFF_FFFE, then 32'h0000_0003.
- Stall cadence: run 99 cycles → o_ready low exactly at cycles 33, 66, 99. o_header_ready high on 16 cycles per 33.
- Drain check: 16 blocks of a header=01 / incrementing-data pattern → bit stream concatenated from o_data (LSB first) equals the concatenated 66-bit blocks. L=0 at each seq=0.
- Async reset at seq 17 → outputs 0 immediately without a clock. After release, the first o_data word carries the new header in bits [1:0].
- Loopback into rx_gearbox with random blocks → after the receiver slips to lock, recovered headers and data match the transmitted sequence for ≥1000 blocks.
